// File: rtl/rx_symbol_framer_if.sv
`default_nettype none
// ============================================================================
// rx_symbol_framer_if : symbol input, tagged-word FIFO output and status bundle
// Rev 1.0
// ============================================================================
interface rx_symbol_framer_if #(
    parameter int CNT_W = 16
);
    logic [11:0]      io_rxSymbols;
    logic             io_rxValid;
    logic [11:0]      io_out_data;
    logic             io_out_sof;
    logic             io_out_eof;
    logic             io_out_err;
    logic             io_out_valid;
    logic             io_out_ready;
    logic             io_in_frame;
    logic [CNT_W-1:0] io_sym_errs;
    logic [CNT_W-1:0] io_frames;
    logic             io_overflow;

    modport master (
        output io_rxSymbols, io_rxValid, io_out_ready,
        input  io_out_data, io_out_sof, io_out_eof, io_out_err, io_out_valid,
        input  io_in_frame, io_sym_errs, io_frames, io_overflow
    );

    modport slave (
        input  io_rxSymbols, io_rxValid, io_out_ready,
        output io_out_data, io_out_sof, io_out_eof, io_out_err, io_out_valid,
        output io_in_frame, io_sym_errs, io_frames, io_overflow
    );
endinterface
`default_nettype wire

// File: rtl/rx_symbol_framer.sv
`default_nettype none
// ============================================================================
// rx_symbol_framer : finds SSD/ESD delimiters in PAM5 symbol words, tags payload
//                    with sof/eof/err and buffers it in a valid/ready FIFO
// Rev 1.0
// ============================================================================
module rx_symbol_framer #(
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_WORDS  = 1024,
    parameter int CNT_W      = 16
) (
    input  wire logic         clock,
    input  wire logic         reset,
    rx_symbol_framer_if.slave bus
);

    localparam int          c_AW      = $clog2(FIFO_DEPTH);
    localparam int          c_WC_W    = $clog2(MAX_WORDS + 1);
    localparam logic [11:0] c_SSD1    = 12'h492;
    localparam logic [11:0] c_SSD2    = 12'h4B6;
    localparam logic [11:0] c_ESD1    = 12'hDB6;
    localparam logic [11:0] c_ESD2    = 12'hD92;
    localparam logic [c_WC_W-1:0] c_MAX_CNT = c_WC_W'(MAX_WORDS);
    localparam logic [c_AW:0]     c_FULL    = (c_AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_HUNT     = 2'd0,
        S_SSD_WAIT = 2'd1,
        S_DATA     = 2'd2,
        S_ESD_WAIT = 2'd3
    } state_t;

    function automatic logic f_illegal(input logic [11:0] w);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (w[3*i +: 3] == 3'b011 || w[3*i +: 3] == 3'b100 || w[3*i +: 3] == 3'b101)
                bad = 1'b1;
        end
        return bad;
    endfunction

    state_t             r_state, w_state_nxt;
    logic               r_first;
    logic               r_pend_valid;
    logic [11:0]        r_pend_data;
    logic               r_pend_sof;
    logic [c_WC_W-1:0]  r_word_cnt;

    logic [14:0]        r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [c_AW:0]      r_count;

    logic [CNT_W-1:0]   r_sym_errs, r_frames;
    logic               r_overflow;

    logic               w_illegal;
    logic               w_wr_en, w_wr_eof, w_wr_err;
    logic               w_load, w_first_set, w_clear_pend;
    logic               w_full, w_empty, w_rd, w_wr_ok;
    logic [11:0]        w_sym;
    logic [14:0]        w_head;

    assign w_sym     = bus.io_rxSymbols;
    assign w_illegal = bus.io_rxValid && f_illegal(w_sym);

    always_comb begin
        w_state_nxt  = r_state;
        w_wr_en      = 1'b0;
        w_wr_eof     = 1'b0;
        w_wr_err     = 1'b0;
        w_load       = 1'b0;
        w_first_set  = 1'b0;
        w_clear_pend = 1'b0;
        if (bus.io_rxValid) begin
            case (r_state)
                S_HUNT: begin
                    if (w_sym == c_SSD1) w_state_nxt = S_SSD_WAIT;
                end
                S_SSD_WAIT: begin
                    if (w_sym == c_SSD2) begin
                        w_state_nxt = S_DATA;
                        w_first_set = 1'b1;
                    end else if (w_sym != c_SSD1) begin
                        w_state_nxt = S_HUNT;
                    end
                end
                S_DATA: begin
                    if (w_sym == c_ESD1) begin
                        w_state_nxt = S_ESD_WAIT;
                    end else if (w_illegal || r_word_cnt == c_MAX_CNT) begin
                        // Abort: close out the held word as an errored end of frame
                        w_wr_en      = r_pend_valid;
                        w_wr_eof     = 1'b1;
                        w_wr_err     = 1'b1;
                        w_clear_pend = 1'b1;
                        w_state_nxt  = S_HUNT;
                    end else begin
                        w_wr_en = r_pend_valid;
                        w_load  = 1'b1;
                    end
                end
                S_ESD_WAIT: begin
                    w_wr_en      = r_pend_valid;
                    w_wr_eof     = 1'b1;
                    w_wr_err     = (w_sym != c_ESD2);
                    w_clear_pend = 1'b1;
                    w_state_nxt  = S_HUNT;
                end
                default: w_state_nxt = S_HUNT;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_HUNT;
            r_first      <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_pend_sof   <= 1'b0;
            r_word_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_first_set) begin
                r_first      <= 1'b1;
                r_word_cnt   <= '0;
                r_pend_valid <= 1'b0;
            end
            if (w_load) begin
                r_pend_valid <= 1'b1;
                r_pend_data  <= w_sym;
                r_pend_sof   <= r_first;
                r_first      <= 1'b0;
                r_word_cnt   <= r_word_cnt + c_WC_W'(1);
            end
            if (w_clear_pend) r_pend_valid <= 1'b0;
        end
    end

    // A full FIFO still takes a write when the head is popped in the same cycle
    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);
    assign w_rd    = !w_empty && bus.io_out_ready;
    assign w_wr_ok = w_wr_en && (!w_full || w_rd);

    always_ff @(posedge clock) begin
        if (w_wr_ok) r_mem[r_wr_ptr] <= {r_pend_data, r_pend_sof, w_wr_eof, w_wr_err};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_sym_errs <= '0;
            r_frames   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_rd)    r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_wr_ok, w_rd})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_illegal && r_sym_errs != '1)
                r_sym_errs <= r_sym_errs + CNT_W'(1);
            if (w_wr_ok && w_wr_eof && !w_wr_err && r_frames != '1)
                r_frames <= r_frames + CNT_W'(1);
            if (w_wr_en && w_full && !w_rd)
                r_overflow <= 1'b1;
        end
    end

    assign w_head           = w_empty ? 15'd0 : r_mem[r_rd_ptr];
    assign bus.io_out_data  = w_head[14:3];
    assign bus.io_out_sof   = w_head[2];
    assign bus.io_out_eof   = w_head[1];
    assign bus.io_out_err   = w_head[0];
    assign bus.io_out_valid = !w_empty;
    assign bus.io_in_frame  = (r_state == S_DATA) || (r_state == S_ESD_WAIT);
    assign bus.io_sym_errs  = r_sym_errs;
    assign bus.io_frames    = r_frames;
    assign bus.io_overflow  = r_overflow;

endmodule
`default_nettype wire
